// File: rtl/risc_datapath.sv
// ----------------------------------------------------------------------------
// risc_datapath
//
// Sequential half of the 8-instruction accumulator CPU. It holds the phase
// counter, program counter, instruction register, accumulator, a
// 2**AWIDTH x DWIDTH program/data memory and the ALU. It returns opcode,
// phase and zero to the combinational controller and acts on the strobes the
// controller sends back.
//
// Optional build macro: RISC_BUS_CHECK_EN
//   defined     -> bus_err is a sticky flag, set on any edge where rd and
//                  data_e are both high, and cleared only by rst.
//   not defined -> bus_err is tied low and no checking logic is built.
//
// Parameters
//   AWIDTH     memory address width, also the IR operand width (default 5)
//   DWIDTH     data / accumulator / IR width (default 8); the opcode is the
//              top DWIDTH-AWIDTH = 3 bits of the IR
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   sel        address mux select: 1 = PC, 0 = IR operand
//   rd         memory drives the data bus (asynchronous read)
//   ld_ir      IR <= bus
//   inc_pc     PC <= PC + 1 (wraps)
//   halt       stop the machine at this edge
//   ld_pc      PC <= IR operand (wins over inc_pc)
//   data_e     accumulator drives the data bus when rd is low
//   ld_ac      AC <= ALU result
//   wr         mem[addr] <= bus
//   prog_we    program-load write, honoured only in reset or when halted
//   prog_addr  program-load address
//   prog_data  program-load data
//   opcode     IR opcode field
//   phase      current phase 0..7
//   zero       accumulator equals zero
//   halted     machine stopped
//   pc         program counter (debug)
//   ac         accumulator (debug)
//   bus_err    sticky rd/data_e contention flag
// ----------------------------------------------------------------------------
module risc_datapath #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              rd,
    input  logic              ld_ir,
    input  logic              inc_pc,
    input  logic              halt,
    input  logic              ld_pc,
    input  logic              data_e,
    input  logic              ld_ac,
    input  logic              wr,
    input  logic              prog_we,
    input  logic [AWIDTH-1:0] prog_addr,
    input  logic [DWIDTH-1:0] prog_data,
    output logic [2:0]        opcode,
    output logic [2:0]        phase,
    output logic              zero,
    output logic              halted,
    output logic [AWIDTH-1:0] pc,
    output logic [DWIDTH-1:0] ac,
    output logic              bus_err
);

    typedef enum logic [2:0] {
        OP_HLT = 3'd0,
        OP_SKZ = 3'd1,
        OP_ADD = 3'd2,
        OP_AND = 3'd3,
        OP_XOR = 3'd4,
        OP_LDA = 3'd5,
        OP_STO = 3'd6,
        OP_JMP = 3'd7
    } opcode_e;

    localparam int DEPTH = 2 ** AWIDTH;

    // Architectural state
    logic [2:0]        phase_q, phase_d;
    logic [AWIDTH-1:0] pc_q,    pc_d;
    logic [DWIDTH-1:0] ir_q,    ir_d;
    logic [DWIDTH-1:0] ac_q,    ac_d;
    logic              halted_q, halted_d;
    logic [DWIDTH-1:0] mem_q [DEPTH];

    // Datapath nets
    opcode_e           op;
    logic [AWIDTH-1:0] addr;
    logic [DWIDTH-1:0] bus;
    logic [DWIDTH-1:0] alu_res;

    assign op   = opcode_e'(ir_q[DWIDTH-1 -: 3]);
    assign addr = sel ? pc_q : ir_q[AWIDTH-1:0];

    // Memory has priority over the accumulator on the shared bus.
    always_comb begin
        if (rd) begin
            bus = mem_q[addr];
        end else if (data_e) begin
            bus = ac_q;
        end else begin
            bus = '0;
        end
    end

    always_comb begin
        alu_res = ac_q;
        case (op)
            OP_ADD:  alu_res = ac_q + bus;
            OP_AND:  alu_res = ac_q & bus;
            OP_XOR:  alu_res = ac_q ^ bus;
            OP_LDA:  alu_res = bus;
            default: alu_res = ac_q;
        endcase
    end

    // Every strobe, including halt itself, acts only while running. The edge
    // that sets halted still advances the phase and applies the other
    // strobes, so the phase freezes at its advanced value.
    always_comb begin
        // NOTE: every next-state variable is given its hold value first so no
        // path through this block can leave it unassigned and infer a latch.
        phase_d  = phase_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        ac_d     = ac_q;
        halted_d = halted_q;
        if (!halted_q) begin
            phase_d = phase_q + 3'd1;
            if (halt) begin
                halted_d = 1'b1;
            end
            if (ld_ir) begin
                ir_d = bus;
            end
            if (ld_pc) begin
                pc_d = ir_q[AWIDTH-1:0];
            end else if (inc_pc) begin
                pc_d = pc_q + AWIDTH'(1);
            end
            if (ld_ac) begin
                ac_d = alu_res;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: registers take non-blocking assignments so every flop samples
        // the pre-edge values regardless of statement order.
        if (rst) begin
            phase_q  <= '0;
            pc_q     <= '0;
            ir_q     <= '0;
            ac_q     <= '0;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            ac_q     <= ac_d;
            halted_q <= halted_d;
        end
    end

    // NOTE: the memory array has no reset; it keeps its contents across rst
    // so a program loaded during reset survives it.
    // A program-load write is accepted only in reset or when halted and then
    // takes priority over a wr strobe; wr itself is dropped on a reset edge.
    always_ff @(posedge clk) begin
        if (prog_we && (rst || halted_q)) begin
            mem_q[prog_addr] <= prog_data;
        end else if (wr && !rst && !halted_q) begin
            mem_q[addr] <= bus;
        end
    end

`ifdef RISC_BUS_CHECK_EN
    logic bus_err_q, bus_err_d;

    // Sticky: any edge with both bus drivers enabled sets it, even when halted.
    assign bus_err_d = bus_err_q | (rd & data_e);

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= bus_err_d;
        end
    end

    assign bus_err = bus_err_q;
`else
    assign bus_err = 1'b0;
`endif

    assign opcode = ir_q[DWIDTH-1 -: 3];
    assign phase  = phase_q;
    assign zero   = (ac_q == '0);
    assign halted = halted_q;
    assign pc     = pc_q;
    assign ac     = ac_q;

endmodule

// File: tb/tb_risc_datapath.sv
// ----------------------------------------------------------------------------
// tb_risc_datapath
//
// Directed bench for risc_datapath. The bench plays the controller: it drives
// the strobe pattern of each phase for a known opcode and compares the debug
// outputs against hand-computed values. Inputs change just after the falling
// edge; outputs are sampled on the falling edge after the rising edge that
// acts on them.
//
// Program held in memory (loaded during reset):
//   0: A3 LDA 3    -> AC = 5C          20: F0
//   1: E8 JMP 8                        21: 20
//   8: B4 LDA 20   -> AC = F0          22: 10
//   9: 55 ADD 21   -> AC = 10 (wrap)   23: 77
//  10: 96 XOR 22   -> AC = 00           3: 5C
//  11: B7 LDA 23   -> AC = 77          31: 00 (overwritten by STO)
//  12: DF STO 31   -> mem[31] = 77
//  13: 97 XOR 23   -> AC = 00
//  14: BF LDA 31   -> AC = 77
//  15: FF JMP 31   -> PC = 31
//  31: 77 AND 23   -> AC = 77, PC wraps to 0
// ----------------------------------------------------------------------------
module tb_risc_datapath;

    logic       clk;
    logic       rst;
    logic       sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr;
    logic       prog_we;
    logic [4:0] prog_addr;
    logic [7:0] prog_data;
    logic [2:0] opcode;
    logic [2:0] phase;
    logic       zero;
    logic       halted;
    logic [4:0] pc;
    logic [7:0] ac;
    logic       bus_err;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef RISC_BUS_CHECK_EN
    localparam logic EXP_BUS_ERR = 1'b1;
`else
    localparam logic EXP_BUS_ERR = 1'b0;
`endif

    risc_datapath #(.AWIDTH(5), .DWIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .sel       (sel),
        .rd        (rd),
        .ld_ir     (ld_ir),
        .inc_pc    (inc_pc),
        .halt      (halt),
        .ld_pc     (ld_pc),
        .data_e    (data_e),
        .ld_ac     (ld_ac),
        .wr        (wr),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .opcode    (opcode),
        .phase     (phase),
        .zero      (zero),
        .halted    (halted),
        .pc        (pc),
        .ac        (ac),
        .bus_err   (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_strobes();
        {sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr} = '0;
        prog_we   = 1'b0;
        prog_addr = '0;
        prog_data = '0;
    endtask

    task automatic load_word(input logic [4:0] a, input logic [7:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        tick();
        prog_we   = 1'b0;
    endtask

    // One instruction, phases 0..7, strobes as the controller would drive
    // them for opcode op. HLT stops after the phase 4 edge.
    task automatic run_instr(input logic [2:0] op);
        bit alu_op;
        alu_op = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
        for (int p = 0; p < 8; p++) begin
            sel    = (p < 4);
            rd     = (p >= 1 && p <= 3) || (alu_op && p >= 5);
            ld_ir  = (p == 2) || (p == 3);
            inc_pc = (p == 4);
            halt   = (p == 4) && (op == 3'd0);
            ld_pc  = (op == 3'd7) && (p >= 6);
            data_e = (op == 3'd6) && (p >= 6);
            ld_ac  = alu_op && (p == 7);
            wr     = (op == 3'd6) && (p == 7);
            tick();
            if (op == 3'd0 && p == 4) break;
        end
        {sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr} = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_strobes();
        rst = 1'b1;

        // Program load while in reset.
        @(negedge clk);
        load_word(5'd0,  8'hA3);
        load_word(5'd1,  8'hE8);
        load_word(5'd3,  8'h5C);
        load_word(5'd8,  8'hB4);
        load_word(5'd9,  8'h55);
        load_word(5'd10, 8'h96);
        load_word(5'd11, 8'hB7);
        load_word(5'd12, 8'hDF);
        load_word(5'd13, 8'h97);
        load_word(5'd14, 8'hBF);
        load_word(5'd15, 8'hFF);
        load_word(5'd20, 8'hF0);
        load_word(5'd21, 8'h20);
        load_word(5'd22, 8'h10);
        load_word(5'd23, 8'h77);
        load_word(5'd31, 8'h00);
        tick();
        tick();
        rst = 1'b0;

        check("rst_phase",   phase,   0);
        check("rst_pc",      pc,      0);
        check("rst_opcode",  opcode,  0);
        check("rst_ac",      ac,      0);
        check("rst_zero",    zero,    1);
        check("rst_halted",  halted,  0);
        check("rst_bus_err", bus_err, 0);

        for (int i = 1; i <= 8; i++) begin
            tick();
            check($sformatf("phase_seq_%0d", i), phase, i % 8);
        end
        check("idle_pc", pc, 0);

        // LDA 3, with a program-load write that must be ignored while running.
        prog_we   = 1'b1;
        prog_addr = 5'd20;
        prog_data = 8'h00;
        sel       = 1'b1;
        tick();
        prog_we   = 1'b0;
        // Phase 0 was consumed above; finish the remaining phases.
        for (int p = 1; p < 8; p++) begin
            sel    = (p < 4);
            rd     = (p <= 3) || (p >= 5);
            ld_ir  = (p == 2) || (p == 3);
            inc_pc = (p == 4);
            ld_ac  = (p == 7);
            if (p == 3) begin
                tick();
                check("lda_ir_valid_opcode", opcode, 5);
            end else begin
                tick();
            end
        end
        clear_strobes();
        check("lda_ac",     ac,     8'h5C);
        check("lda_pc",     pc,     1);
        check("lda_zero",   zero,   0);
        check("lda_opcode", opcode, 5);
        check("lda_phase",  phase,  0);

        run_instr(3'd7);
        check("jmp8_pc", pc, 8);

        run_instr(3'd5);
        check("lda20_ac_prog_we_ignored", ac, 8'hF0);

        run_instr(3'd2);
        check("add_wrap_ac", ac, 8'h10);
        check("add_pc",      pc, 10);

        run_instr(3'd4);
        check("xor_ac",   ac,   8'h00);
        check("xor_zero", zero, 1);

        run_instr(3'd5);
        check("lda23_ac", ac, 8'h77);

        run_instr(3'd6);
        check("sto_ac_unchanged", ac,     8'h77);
        check("sto_opcode",       opcode, 6);

        run_instr(3'd4);
        check("xor23_ac", ac, 8'h00);

        run_instr(3'd5);
        check("sto_mem31", ac, 8'h77);

        run_instr(3'd7);
        check("jmp31_pc", pc, 31);

        run_instr(3'd3);
        check("pc_wrap",    pc,     0);
        check("and_opcode", opcode, 3);
        check("and_ac",     ac,     8'h77);

        // Reset mid-run, loading a HLT at address 0.
        rst = 1'b1;
        load_word(5'd0, 8'h00);
        rst = 1'b0;
        check("rst2_pc", pc, 0);
        check("rst2_ac", ac, 0);

        run_instr(3'd0);
        check("hlt_halted", halted, 1);
        check("hlt_pc",     pc,     1);
        check("hlt_phase",  phase,  5);
        check("hlt_opcode", opcode, 0);

        // Strobes while halted must have no effect.
        {sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr} = 9'b1_1111_1011;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("halt_phase_%0d", i), phase, 5);
        end
        {sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr} = '0;
        check("halt_pc_frozen",     pc,     1);
        check("halt_opcode_frozen", opcode, 0);
        check("halt_ac_frozen",     ac,     0);
        check("halt_still_halted",  halted, 1);

        // Program load accepted while halted: LDA 20 at address 0.
        load_word(5'd0, 8'hB4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("resume_halted", halted, 0);
        check("resume_phase",  phase,  0);
        check("resume_pc",     pc,     0);

        run_instr(3'd5);
        check("halt_prog_we_ac", ac, 8'hF0);
        check("halt_prog_we_pc", pc, 1);

        // Bus contention.
        sel    = 1'b1;
        rd     = 1'b1;
        data_e = 1'b1;
        tick();
        rd     = 1'b0;
        data_e = 1'b0;
        sel    = 1'b0;
        check("bus_err_set", bus_err, EXP_BUS_ERR);
        tick();
        check("bus_err_held", bus_err, EXP_BUS_ERR);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("bus_err_cleared", bus_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
